// File: rtl/btn_repeat.sv
// btn_repeat: push-button front end for the clock/timer counters.
// Raw button levels pass through a 2-FF synchroniser. A slow sample tick
// then debounces them. Each accepted press gives a one-CLK PULSE, and
// buttons with their mask bit set also give auto-repeat pulses while held.
// LEVEL carries the debounced pressed state.

module btn_repeat #(
    parameter int               N            = 3,
    parameter int               SAMPLE_DIV   = 500000,
    parameter int               REPEAT_DELAY = 50,
    parameter int               REPEAT_RATE  = 10,
    parameter logic [N-1:0]     REPEAT_MASK  = 3'b011
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] nBUTTON,
    output logic [N-1:0] PULSE,
    output logic [N-1:0] LEVEL
);

    // Tick counter width. SAMPLE_DIV >= 2 keeps this at least one bit.
    localparam int CW = $clog2(SAMPLE_DIV);
    // The hold counter is one bit wider than needed to reach REPEAT_DELAY-1,
    // so it can never wrap.
    localparam int HW = $clog2(REPEAT_DELAY) + 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] HC_LAST   = HW'(REPEAT_DELAY - 1);
    // After a repeat, the counter reloads to this value so that the next
    // repeat comes REPEAT_RATE ticks later.
    localparam logic [HW-1:0] HC_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE);

    logic [N-1:0]    sync_meta;
    logic [N-1:0]    s;
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic [N-1:0]    prev;
    logic [N-1:0]    agree;
    logic [HW-1:0]   hc [N];

    // Two-flop synchroniser: nBUTTON is asynchronous to CLK.
    // NOTE: sequential state uses non-blocking (<=) assignments only. Every
    // flop then samples the values from before the edge, and the result does
    // not depend on the order in which the processes run.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_meta <= '0;
            s         <= '0;
        end else begin
            sync_meta <= nBUTTON;
            s         <= sync_meta;
        end
    end

    // Free-running divider. tick is high for the single count SAMPLE_DIV-1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    assign tick  = (tick_cnt == TICK_LAST);

    // Two consecutive tick samples agree when the current s matches the
    // sample stored on the previous tick.
    assign agree = ~(s ^ prev);

    // Per-button debounce, press/release acceptance and auto-repeat timing.
    // All buttons are updated in parallel and never interact.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev  <= '0;
            LEVEL <= '0;
            PULSE <= '0;
            // NOTE: the hold counters are a small register array, not a RAM,
            // so clearing them in reset costs nothing. Clearing them also
            // ensures that a hold interrupted by reset restarts from a known
            // point.
            for (int i = 0; i < N; i++) begin
                hc[i] <= '0;
            end
        end else begin
            // A pulse lasts exactly one CLK. The default is low, and only a
            // tick edge can raise it.
            PULSE <= '0;
            if (tick) begin
                prev <= s;
                for (int i = 0; i < N; i++) begin
                    if (agree[i] && s[i] && !LEVEL[i]) begin
                        // Press accepted: this is the only non-repeat pulse.
                        LEVEL[i] <= 1'b1;
                        PULSE[i] <= 1'b1;
                        hc[i]    <= '0;
                    end else if (agree[i] && !s[i] && LEVEL[i]) begin
                        // Release accepted. It takes priority over a repeat
                        // due on the same tick.
                        LEVEL[i] <= 1'b0;
                        hc[i]    <= '0;
                    end else if (LEVEL[i]) begin
                        // The button is still held. A disagreeing sample is
                        // bounce and leaves LEVEL unchanged.
                        if (REPEAT_MASK[i] && (hc[i] == HC_LAST)) begin
                            PULSE[i] <= 1'b1;
                            hc[i]    <= HC_RELOAD;
                        end else if (REPEAT_MASK[i] || (hc[i] != HC_LAST)) begin
                            // A button without repeat saturates at HC_LAST.
                            hc[i] <= hc[i] + HW'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_btn_repeat.sv
// Self-checking bench for btn_repeat. It runs the directed scenarios for
// press, repeat, release, bounce, a button without repeat, simultaneous
// presses and reset during a hold. After those come randomized
// hold/bounce segments. A tick-level reference model checks every cycle.

module tb_btn_repeat;

    localparam int         N    = 3;
    localparam int         DIV  = 4;
    localparam int         RD   = 5;
    localparam int         RR   = 2;
    localparam logic [2:0] MASK = 3'b011;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] nBUTTON;
    logic [N-1:0] PULSE;
    logic [N-1:0] LEVEL;

    btn_repeat #(
        .N            (N),
        .SAMPLE_DIV   (DIV),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .REPEAT_MASK  (MASK)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .nBUTTON (nBUTTON),
        .PULSE   (PULSE),
        .LEVEL   (LEVEL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (tick-level rules) ----------------
    // cyc_n counts CLK edges since reset release. Edge n is a tick edge when
    // n is a multiple of DIV. The sample seen at that edge is the button
    // level that was present two edges earlier.
    int           cyc_n;
    int           tick_idx;
    logic [N-1:0] sh1, sh2, m_s, m_prev;
    logic [N-1:0] exp_level, exp_pulse;
    int           acc_tick [N];
    int           m_d;

    task automatic model_reset();
        cyc_n     = 0;
        tick_idx  = 0;
        sh1       = '0;
        sh2       = '0;
        m_prev    = '0;
        exp_level = '0;
        exp_pulse = '0;
        for (int i = 0; i < N; i++) acc_tick[i] = 0;
    endtask

    task automatic model_step();
        m_s = sh2;
        sh2 = sh1;
        sh1 = nBUTTON;
        cyc_n++;
        exp_pulse = '0;
        if (cyc_n % DIV == 0) begin
            tick_idx++;
            for (int i = 0; i < N; i++) begin
                if (m_s[i] == m_prev[i] && m_s[i] && !exp_level[i]) begin
                    exp_level[i] = 1'b1;
                    exp_pulse[i] = 1'b1;
                    acc_tick[i]  = tick_idx;
                end else if (m_s[i] == m_prev[i] && !m_s[i] && exp_level[i]) begin
                    exp_level[i] = 1'b0;
                end else if (exp_level[i] && MASK[i]) begin
                    // Repeats come at offsets RD, RD+RR, RD+2RR, ... from the accept tick.
                    m_d = tick_idx - acc_tick[i];
                    if (m_d >= RD && (m_d - RD) % RR == 0) exp_pulse[i] = 1'b1;
                end
            end
            m_prev = m_s;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) model_reset();
            else     model_step();
        end
    end

    // Compare with the model at every falling edge, and count pulses and LEVEL rises.
    int           pulse_cnt [N];
    int           rise_cnt  [N];
    logic [N-1:0] level_d;

    initial begin
        for (int i = 0; i < N; i++) begin
            pulse_cnt[i] = 0;
            rise_cnt[i]  = 0;
        end
        level_d = '0;
        forever begin
            @(negedge CLK);
            check("model_pulse", PULSE, exp_pulse);
            check("model_level", LEVEL, exp_level);
            for (int i = 0; i < N; i++) begin
                if (PULSE[i]) pulse_cnt[i]++;
                if (LEVEL[i] && !level_d[i]) rise_cnt[i]++;
            end
            level_d = LEVEL;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_ticks(input int k);
        repeat (DIV * k) @(negedge CLK);
    endtask

    // Release all buttons and let every debounced level settle back to 0.
    task automatic idle();
        nBUTTON = '0;
        wait_ticks(5);
        check("idle_level", LEVEL, 3'b000);
    endtask

    // Bounded wait for LEVEL[b] to rise. The wait returns on the falling edge
    // at accept offset 0.
    task automatic wait_level(input int b);
        int k;
        k = 0;
        while (!LEVEL[b] && k < 40) begin
            @(negedge CLK);
            k++;
        end
        check("level_rise", {31'd0, LEVEL[b]}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int base0, base1, base2, rbase, k;

    initial begin
        RST     = 1'b0;
        nBUTTON = '0;
        #1 RST  = 1'b1;
        #2;
        check("reset_pulse", PULSE, 3'b000);
        check("reset_level", LEVEL, 3'b000);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        idle();

        // 1: bit0 held for 30 ticks. Pulses at offsets 0,5,7,...,29 give 14 in total.
        base0 = pulse_cnt[0];
        nBUTTON = 3'b001;
        wait_level(0);
        check("t1_press_pulse", PULSE, 3'b001);
        wait_ticks(29);
        check("t1_level_held", LEVEL, 3'b001);
        nBUTTON = 3'b000;
        idle();
        check("t1_pulse_count", pulse_cnt[0] - base0, 14);

        // 2: bit1. The first 0 sample comes at offset 40, so the pulses are 0,5,...,39 (19 in total).
        base1 = pulse_cnt[1];
        nBUTTON = 3'b010;
        wait_level(1);
        wait_ticks(39);
        nBUTTON = 3'b000;
        wait_ticks(1);
        check("t2_level_off40", LEVEL, 3'b010);
        wait_ticks(1);
        check("t2_level_off41", LEVEL, 3'b000);
        check("t2_no_pulse41", PULSE, 3'b000);
        idle();
        check("t2_pulse_count", pulse_cnt[1] - base1, 19);

        // 3: bit0 toggles every CLK for 3 ticks, then is held for 3 ticks, then released.
        base0 = pulse_cnt[0];
        rbase = rise_cnt[0];
        for (int i = 0; i < 3 * DIV; i++) begin
            nBUTTON = {2'b00, 1'((cyc_n + 1) % 2)};
            @(negedge CLK);
        end
        check("t3_level_during_bounce", LEVEL, 3'b000);
        nBUTTON = 3'b001;
        wait_ticks(3);
        nBUTTON = 3'b000;
        idle();
        check("t3_pulse_count", pulse_cnt[0] - base0, 1);
        check("t3_level_rises", rise_cnt[0] - rbase, 1);

        // 4: bit2 has repeat disabled. Holding it for 30 ticks gives a single pulse.
        base2 = pulse_cnt[2];
        nBUTTON = 3'b100;
        wait_level(2);
        wait_ticks(29);
        check("t4_level_held", LEVEL, 3'b100);
        nBUTTON = 3'b000;
        wait_ticks(1);
        check("t4_level_off30", LEVEL, 3'b100);
        wait_ticks(1);
        check("t4_level_off31", LEVEL, 3'b000);
        idle();
        check("t4_pulse_count", pulse_cnt[2] - base2, 1);

        // 5: bits 0 and 1 are pressed on the same CLK. Pulses at offsets 0,5,7,9,11 give 5 each.
        base0 = pulse_cnt[0];
        base1 = pulse_cnt[1];
        nBUTTON = 3'b011;
        k = 0;
        while (PULSE == 3'b000 && k < 40) begin
            @(negedge CLK);
            k++;
        end
        check("t5_simultaneous", PULSE, 3'b011);
        wait_ticks(11);
        nBUTTON = 3'b000;
        idle();
        check("t5_count_bit0", pulse_cnt[0] - base0, 5);
        check("t5_count_bit1", pulse_cnt[1] - base1, 5);

        // 6: reset at offset 6 of a bit0 hold while the button stays pressed.
        nBUTTON = 3'b001;
        wait_level(0);
        wait_ticks(6);
        #2 RST = 1'b1;
        #1;
        check("t6_async_level", LEVEL, 3'b000);
        check("t6_async_pulse", PULSE, 3'b000);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!PULSE[0] && k < 40);
        check("t6_repress_latency", k, 2 * DIV);
        wait_ticks(4);
        check("t6_no_repeat_off4", PULSE, 3'b000);
        wait_ticks(1);
        check("t6_repeat_off5", PULSE, 3'b001);
        idle();

        // Randomized holds with occasional single-cycle bounce, checked against the model.
        for (int seg = 0; seg < 30; seg++) begin
            logic [N-1:0] pat;
            int           dur;
            pat = 3'($urandom_range(0, 7));
            dur = $urandom_range(4, 100);
            for (int c = 0; c < dur; c++) begin
                if ($urandom_range(0, 9) == 0) nBUTTON = pat ^ 3'($urandom_range(1, 7));
                else                           nBUTTON = pat;
                @(negedge CLK);
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
